// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU core: MIPS opcode/funct values,
// flag bit positions, FSM state and shift-kind encodings.
// No logic; imported by alu_seq_core and alu_regfile.
package alu_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Flag bit indices
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_kind_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file, NUM_REGS x DATA_W, two async read ports, writeback + external write ports.
// Latency: reads combinational, writes land on the rising edge.
// Backpressure: none; an external write to the same entry as a writeback wins.
// Ports: rd_addr_a/b -> rd_data_a/b; wb_en/wb_addr/wb_data; ext_en/ext_addr/ext_data
//        (ext_addr is 5 bits wide, entries >= NUM_REGS are ignored).
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4,
    parameter int AW       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ext_en,
    input  logic [4:0]        ext_addr,
    input  logic [DATA_W-1:0] ext_data
);
    localparam logic [AW:0] NR_A = (AW+1)'(NUM_REGS);
    localparam logic [5:0]  NR_X = 6'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic          ext_hit;
    logic          wb_hit;
    logic [AW-1:0] ext_idx;

    assign ext_hit = ext_en && ({1'b0, ext_addr} < NR_X);
    assign wb_hit  = wb_en && ({1'b0, wb_addr} < NR_A);
    assign ext_idx = AW'(ext_addr);

    // Out-of-range indices only exist when NUM_REGS is not a power of two.
    assign rd_data_a = ({1'b0, rd_addr_a} < NR_A) ? regs[rd_addr_a] : '0;
    assign rd_data_b = ({1'b0, rd_addr_b} < NR_A) ? regs[rd_addr_b] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_hit) begin
                regs[wb_addr] <= wb_data;
            end
            // Issued last so it overrides a writeback to the same entry.
            if (ext_hit) begin
                regs[ext_idx] <= ext_data;
            end
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked MIPS-subset ALU with internal register file and optional bit-serial shifter.
// Latency: out_valid 1 cycle after accept; iterative shifts by n take 1+n cycles.
// Backpressure: in_ready only in IDLE; result/flags/illegal held in DONE until out_ready.
// Ports: in_valid/in_ready/instruction, reg_wr_en/reg_wr_addr/reg_wr_data (preload),
//        out_valid/out_ready/result/flags[Z,N,V]/illegal.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 4,
    parameter int ITER_SHIFT = 1,
    parameter int WRITEBACK  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic              reg_wr_en,
    input  logic [4:0]        reg_wr_addr,
    input  logic [DATA_W-1:0] reg_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        flags,
    output logic              illegal
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int SW = $clog2(DATA_W);
    localparam int M  = DATA_W - 1;

    // ---------------- decode ----------------
    logic [5:0]        opcode, funct;
    logic [AW-1:0]     rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] rs_val, rt_val, simm, zimm;
    logic [SW-1:0]     shamt_amt, rs_amt;

    assign opcode    = instruction[31:26];
    assign funct     = instruction[5:0];
    assign rs_idx    = AW'(instruction[25:21]);
    assign rt_idx    = AW'(instruction[20:16]);
    assign rd_idx    = AW'(instruction[15:11]);
    assign simm      = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
    assign zimm      = {{(DATA_W-16){1'b0}}, instruction[15:0]};
    assign shamt_amt = SW'(instruction[10:6]);
    assign rs_amt    = SW'(rs_val);

    // ---------------- state ----------------
    state_t            state;
    logic [DATA_W-1:0] sh_val;
    logic [SW-1:0]     sh_cnt;
    shift_kind_t       sh_kind;
    logic              wb_pend;
    logic [AW-1:0]     wb_addr;
    logic              wb_en;

    assign wb_en = (WRITEBACK != 0) && (state == ST_DONE) && out_ready && wb_pend;

    alu_regfile #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .AW      (AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_addr_a(rs_idx),
        .rd_data_a(rs_val),
        .rd_addr_b(rt_idx),
        .rd_data_b(rt_val),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (result),
        .ext_en   (reg_wr_en),
        .ext_addr (reg_wr_addr),
        .ext_data (reg_wr_data)
    );

    // ---------------- shift decode + barrel ----------------
    logic              is_shift;
    shift_kind_t       sh_kind_c;
    logic [SW-1:0]     sh_amt_c;
    logic [DATA_W-1:0] barrel;

    always_comb begin
        is_shift  = 1'b0;
        sh_kind_c = SH_LL;
        sh_amt_c  = shamt_amt;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SLL:  begin is_shift = 1'b1; sh_kind_c = SH_LL; end
                FN_SRL:  begin is_shift = 1'b1; sh_kind_c = SH_RL; end
                FN_SRA:  begin is_shift = 1'b1; sh_kind_c = SH_RA; end
                FN_SLLV: begin is_shift = 1'b1; sh_kind_c = SH_LL; sh_amt_c = rs_amt; end
                FN_SRLV: begin is_shift = 1'b1; sh_kind_c = SH_RL; sh_amt_c = rs_amt; end
                FN_SRAV: begin is_shift = 1'b1; sh_kind_c = SH_RA; sh_amt_c = rs_amt; end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (sh_kind_c)
            SH_LL:   barrel = rt_val << sh_amt_c;
            SH_RL:   barrel = rt_val >> sh_amt_c;
            SH_RA:   barrel = DATA_W'($signed(rt_val) >>> sh_amt_c);
            default: barrel = rt_val;
        endcase
    end

    // ---------------- execute ----------------
    logic [DATA_W-1:0] sum_rr, dif_rr, sum_ri;
    logic              ovf_add_rr, ovf_sub_rr, ovf_add_ri;
    logic              slt_rr, sltu_rr, slt_ri, sltu_ri;

    assign sum_rr     = rs_val + rt_val;
    assign dif_rr     = rs_val - rt_val;
    assign sum_ri     = rs_val + simm;
    assign ovf_add_rr = (rs_val[M] == rt_val[M]) && (sum_rr[M] != rs_val[M]);
    assign ovf_sub_rr = (rs_val[M] != rt_val[M]) && (dif_rr[M] != rs_val[M]);
    assign ovf_add_ri = (rs_val[M] == simm[M])   && (sum_ri[M] != rs_val[M]);
    assign slt_rr     = $signed(rs_val) < $signed(rt_val);
    assign sltu_rr    = rs_val < rt_val;
    assign slt_ri     = $signed(rs_val) < $signed(simm);
    assign sltu_ri    = rs_val < simm;

    logic [DATA_W-1:0] ex_result;
    logic [2:0]        ex_flags;
    logic              ex_illegal, ex_wb, ex_wb_rd;

    always_comb begin
        ex_result  = '0;
        ex_flags   = '0;
        ex_illegal = 1'b0;
        ex_wb      = 1'b1;
        ex_wb_rd   = 1'b0;
        if (opcode == OP_RTYPE) begin
            ex_wb_rd = 1'b1;
            case (funct)
                FN_SLL, FN_SRL, FN_SRA,
                FN_SLLV, FN_SRLV, FN_SRAV: ex_result = barrel;
                FN_ADD:  begin ex_result = sum_rr; ex_flags[FLAG_V] = ovf_add_rr; end
                FN_ADDU: ex_result = sum_rr;
                FN_SUB:  begin ex_result = dif_rr; ex_flags[FLAG_V] = ovf_sub_rr; end
                FN_SUBU: ex_result = dif_rr;
                FN_AND:  ex_result = rs_val & rt_val;
                FN_OR:   ex_result = rs_val | rt_val;
                FN_XOR:  ex_result = rs_val ^ rt_val;
                FN_NOR:  ex_result = ~(rs_val | rt_val);
                FN_SLT:  begin ex_result = DATA_W'(slt_rr);  ex_flags[FLAG_N] = slt_rr;  end
                FN_SLTU: begin ex_result = DATA_W'(sltu_rr); ex_flags[FLAG_N] = sltu_rr; end
                default: begin ex_illegal = 1'b1; ex_wb = 1'b0; end
            endcase
        end else begin
            case (opcode)
                OP_BEQ, OP_BNE: begin ex_wb = 1'b0; ex_flags[FLAG_Z] = (rs_val == rt_val); end
                OP_ADDI:  begin ex_result = sum_ri; ex_flags[FLAG_V] = ovf_add_ri; end
                OP_ADDIU: ex_result = sum_ri;
                OP_SLTI:  begin ex_result = DATA_W'(slt_ri);  ex_flags[FLAG_N] = slt_ri;  end
                OP_SLTIU: begin ex_result = DATA_W'(sltu_ri); ex_flags[FLAG_N] = sltu_ri; end
                OP_ANDI:  ex_result = rs_val & zimm;
                OP_ORI:   ex_result = rs_val | zimm;
                OP_XORI:  ex_result = rs_val ^ zimm;
                OP_LW:    ex_result = sum_ri;
                OP_SW:    begin ex_result = sum_ri; ex_wb = 1'b0; end
                default:  begin ex_illegal = 1'b1; ex_wb = 1'b0; end
            endcase
        end
    end

    // ---------------- bit-serial shifter step ----------------
    logic [DATA_W-1:0] sh_next;

    always_comb begin
        case (sh_kind)
            SH_LL:   sh_next = {sh_val[M-1:0], 1'b0};
            SH_RL:   sh_next = {1'b0, sh_val[M:1]};
            SH_RA:   sh_next = {sh_val[M], sh_val[M:1]};
            default: sh_next = sh_val;
        endcase
    end

    // ---------------- FSM + output registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            illegal   <= 1'b0;
            sh_val    <= '0;
            sh_cnt    <= '0;
            sh_kind   <= SH_LL;
            wb_pend   <= 1'b0;
            wb_addr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        flags    <= ex_flags;
                        illegal  <= ex_illegal;
                        wb_pend  <= ex_wb;
                        wb_addr  <= ex_wb_rd ? rd_idx : rt_idx;
                        if ((ITER_SHIFT != 0) && is_shift && (sh_amt_c != '0)) begin
                            state   <= ST_SHIFT;
                            sh_val  <= rt_val;
                            sh_cnt  <= sh_amt_c;
                            sh_kind <= sh_kind_c;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= ex_result;
                        end
                    end
                end
                ST_SHIFT: begin
                    sh_val <= sh_next;
                    sh_cnt <= sh_cnt - SW'(1);
                    if (sh_cnt == SW'(1)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= sh_next;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (DATA_W=32, NUM_REGS=4, ITER_SHIFT=1, WRITEBACK=1).
// Expected results are queued as each instruction is issued and popped at the output handshake.
// Register contents are observed by issuing "or rX,rX,rX" and checking the result.
module tb_alu_seq_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic        reg_wr_en = 1'b0;
    logic [4:0]  reg_wr_addr = '0;
    logic [31:0] reg_wr_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [2:0]  flags;
    logic        illegal;

    alu_seq_core #(
        .DATA_W(32), .NUM_REGS(4), .ITER_SHIFT(1), .WRITEBACK(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        logic        ill;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    int    n_vec = 0;
    int    n_bad = 0;
    string cur_tag = "reset";

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Output side of the scoreboard: one pop per completed handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk({cur_tag, ".sb_underflow"}, 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({cur_tag, ".result"}, result, mon_e.res);
                chk({cur_tag, ".flags"}, 32'(flags), 32'(mon_e.flg));
                chk({cur_tag, ".illegal"}, 32'(illegal), 32'(mon_e.ill));
            end
        end
    end

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    task automatic wr_reg(input int a, input logic [31:0] d);
        reg_wr_en   = 1'b1;
        reg_wr_addr = 5'(a);
        reg_wr_data = d;
        @(posedge clk); #1;
        reg_wr_en = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [2:0] flg, input logic ill);
        exp_t e;
        e.res = res;
        e.flg = flg;
        e.ill = ill;
        sb.push_back(e);
    endtask

    // Present an instruction and hold it until the accept edge has passed.
    task automatic send(input logic [31:0] ins);
        int n;
        in_valid    = 1'b1;
        instruction = ins;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk({cur_tag, ".accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; latency 1 means out_valid is already up.
    task automatic collect(input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({cur_tag, ".latency"}, 32'(lat), 32'(exp_lat));
        if (out_valid && out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] res,
                       input logic [2:0] flg, input logic ill, input int lat);
        cur_tag = tag;
        push_exp(res, flg, ill);
        send(ins);
        collect(lat);
    endtask

    task automatic rd_reg(input int i, input logic [31:0] exp);
        run($sformatf("read_r%0d", i), r_ins(i, i, i, 0, 6'h25), exp, 3'b000, 1'b0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.flags", 32'(flags), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Signed add overflow and writeback to rd
        wr_reg(0, 32'h7FFF_FFFF);
        wr_reg(1, 32'h0000_0001);
        run("add_ovf",  r_ins(0, 1, 2, 0, 6'h20), 32'h8000_0000, 3'b100, 1'b0, 1);
        rd_reg(2, 32'h8000_0000);
        run("addu",     r_ins(0, 1, 3, 0, 6'h21), 32'h8000_0000, 3'b000, 1'b0, 1);

        // Signed vs unsigned compare
        wr_reg(0, 32'hFFFF_FFFF);
        run("slt",      r_ins(0, 1, 3, 0, 6'h2A), 32'h1, 3'b010, 1'b0, 1);
        run("sltu",     r_ins(0, 1, 3, 0, 6'h2B), 32'h0, 3'b000, 1'b0, 1);
        rd_reg(3, 32'h0);

        // Branch compares: no writeback
        wr_reg(0, 32'd5);
        wr_reg(1, 32'd5);
        run("beq_eq",   i_ins(6'h04, 0, 1, 16'h0010), 32'h0, 3'b001, 1'b0, 1);
        rd_reg(1, 32'd5);
        rd_reg(2, 32'h8000_0000);
        wr_reg(1, 32'd6);
        run("beq_ne",   i_ins(6'h04, 0, 1, 16'h0010), 32'h0, 3'b000, 1'b0, 1);
        run("bne_ne",   i_ins(6'h05, 0, 1, 16'h0010), 32'h0, 3'b000, 1'b0, 1);
        run("bne_eq",   i_ins(6'h05, 0, 0, 16'h0010), 32'h0, 3'b001, 1'b0, 1);

        // Subtract overflow
        wr_reg(0, 32'h8000_0000);
        wr_reg(1, 32'h1);
        run("sub_ovf",  r_ins(0, 1, 2, 0, 6'h22), 32'h7FFF_FFFF, 3'b100, 1'b0, 1);
        run("subu",     r_ins(0, 1, 2, 0, 6'h23), 32'h7FFF_FFFF, 3'b000, 1'b0, 1);

        // Immediates: sign vs zero extension, I-type writes rt
        wr_reg(0, 32'h10);
        run("addi_neg", i_ins(6'h08, 0, 2, 16'hFFFF), 32'h0000_000F, 3'b000, 1'b0, 1);
        rd_reg(2, 32'h0000_000F);
        wr_reg(0, 32'hFFFF_FFFF);
        run("andi_zx",  i_ins(6'h0C, 0, 2, 16'h8001), 32'h0000_8001, 3'b000, 1'b0, 1);
        run("slti",     i_ins(6'h0A, 0, 2, 16'h0001), 32'h1, 3'b010, 1'b0, 1);
        run("sltiu",    i_ins(6'h0B, 0, 2, 16'h0001), 32'h0, 3'b000, 1'b0, 1);
        wr_reg(0, 32'h0);
        run("sltiu_sx", i_ins(6'h0B, 0, 2, 16'hFFFF), 32'h1, 3'b010, 1'b0, 1);
        wr_reg(0, 32'h7FFF_FFFF);
        run("addiu",    i_ins(6'h09, 0, 2, 16'h0001), 32'h8000_0000, 3'b000, 1'b0, 1);
        run("addi_ovf", i_ins(6'h08, 0, 2, 16'h0001), 32'h8000_0000, 3'b100, 1'b0, 1);

        // Bitwise
        wr_reg(0, 32'hFF00_FF00);
        wr_reg(1, 32'h0FF0_0FF0);
        run("and",      r_ins(0, 1, 2, 0, 6'h24), 32'h0F00_0F00, 3'b000, 1'b0, 1);
        run("or",       r_ins(0, 1, 2, 0, 6'h25), 32'hFFF0_FFF0, 3'b000, 1'b0, 1);
        run("xor",      r_ins(0, 1, 2, 0, 6'h26), 32'hF0F0_F0F0, 3'b000, 1'b0, 1);
        run("nor",      r_ins(0, 1, 2, 0, 6'h27), 32'h000F_000F, 3'b000, 1'b0, 1);
        run("ori",      i_ins(6'h0D, 1, 2, 16'hF000), 32'h0FF0_FFF0, 3'b000, 1'b0, 1);
        run("xori",     i_ins(6'h0E, 0, 2, 16'hFFFF), 32'hFF00_00FF, 3'b000, 1'b0, 1);

        // Address generation; sw does not write rt
        wr_reg(0, 32'h100);
        wr_reg(3, 32'hAA);
        run("lw",       i_ins(6'h23, 0, 2, 16'hFFFC), 32'h0000_00FC, 3'b000, 1'b0, 1);
        rd_reg(2, 32'h0000_00FC);
        run("sw",       i_ins(6'h2B, 0, 3, 16'h0004), 32'h0000_0104, 3'b000, 1'b0, 1);
        rd_reg(3, 32'hAA);

        // Iterative shifts: latency 1 + amount
        wr_reg(1, 32'h8000_0000);
        run("sra4",     r_ins(0, 1, 2, 4, 6'h03), 32'hF800_0000, 3'b000, 1'b0, 5);
        run("sra0",     r_ins(0, 1, 2, 0, 6'h03), 32'h8000_0000, 3'b000, 1'b0, 1);
        run("srl4",     r_ins(0, 1, 2, 4, 6'h02), 32'h0800_0000, 3'b000, 1'b0, 5);
        wr_reg(1, 32'h1);
        run("sll31",    r_ins(0, 1, 2, 31, 6'h00), 32'h8000_0000, 3'b000, 1'b0, 32);
        wr_reg(0, 32'h3);
        run("sllv3",    r_ins(0, 1, 2, 0, 6'h04), 32'h0000_0008, 3'b000, 1'b0, 4);
        wr_reg(0, 32'h24);
        wr_reg(1, 32'hF000_0000);
        run("srlv_msk", r_ins(0, 1, 2, 0, 6'h06), 32'h0F00_0000, 3'b000, 1'b0, 5);
        wr_reg(0, 32'h8);
        wr_reg(1, 32'h8000_0000);
        run("srav8",    r_ins(0, 1, 2, 0, 6'h07), 32'hFF80_0000, 3'b000, 1'b0, 9);
        rd_reg(2, 32'hFF80_0000);

        // Illegal opcode / funct: no writeback
        run("ill_op",   i_ins(6'h3F, 0, 1, 16'h0000), 32'h0, 3'b000, 1'b1, 1);
        run("ill_fn",   r_ins(0, 1, 2, 0, 6'h3F), 32'h0, 3'b000, 1'b1, 1);
        rd_reg(2, 32'hFF80_0000);

        // Hold in DONE with out_ready low; a waiting instruction must not be taken
        wr_reg(0, 32'd3);
        wr_reg(1, 32'd4);
        out_ready = 1'b0;
        cur_tag = "hold";
        push_exp(32'd7, 3'b000, 1'b0);
        send(r_ins(0, 1, 2, 0, 6'h21));
        in_valid    = 1'b1;
        instruction = r_ins(2, 2, 3, 0, 6'h25);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d.out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d.in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d.result", k), result, 32'd7);
            chk($sformatf("hold%0d.flags", k), 32'(flags), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push_exp(32'd7, 3'b000, 1'b0);
        send(r_ins(2, 2, 3, 0, 6'h25));
        cur_tag = "after_hold";
        collect(1);

        // External write and writeback to the same entry on one edge
        out_ready = 1'b0;
        cur_tag = "wb_conflict";
        push_exp(32'd6, 3'b000, 1'b0);
        send(r_ins(0, 0, 2, 0, 6'h21));
        reg_wr_en   = 1'b1;
        reg_wr_addr = 5'd2;
        reg_wr_data = 32'h1234_5678;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        reg_wr_en = 1'b0;
        rd_reg(2, 32'h1234_5678);

        // External writes beyond NUM_REGS are dropped
        wr_reg(4, 32'hDEAD_BEEF);
        wr_reg(31, 32'hDEAD_BEEF);
        rd_reg(0, 32'd3);

        // Reset in the middle of a long shift
        cur_tag = "rst_shift";
        send(r_ins(0, 1, 2, 20, 6'h03));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_shift.pre_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_shift.out_valid", 32'(out_valid), 32'd0);
        chk("rst_shift.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("rst_shift.dropped", 32'(out_valid), 32'd0);
        for (int r = 0; r < 4; r++) begin
            rd_reg(r, 32'h0);
        end

        chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
